// File: rtl/bist_resp_analyzer_pkg.sv
// Shared BIST definitions: run states and default MISR geometry, used by the
// response analyzer and its MISR core.
package bist_resp_analyzer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPACT = 2'd1,
    COMPARE = 2'd2,
    DONE    = 2'd3
  } bra_state_e;

  localparam int          DEF_SIG_W = 16;
  localparam logic [15:0] DEF_POLY  = 16'h002D;

endpackage

// File: rtl/bist_resp_analyzer_misr_core.sv
// Multiple-input signature register: the signature register plus its feedback
// XOR network. Sequencing is owned by the instantiating analyzer.
module misr_core
  import bist_resp_analyzer_pkg::*;
#(
  parameter int               SIG_W = DEF_SIG_W,
  parameter int               IN_W  = 2,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [SIG_W-1:0] load_val,
  input  logic             shift_en,
  input  logic [IN_W-1:0]  din,
  output logic [SIG_W-1:0] sig
);

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] cur,
                                                 input logic [IN_W-1:0]  beat);
    logic [SIG_W-1:0] fb;
    fb = cur[SIG_W-1] ? POLY : '0;
    return {cur[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(beat);
  endfunction

  // Reset and load both return the register to the seed supplied by the owner.
  always_ff @(posedge CLK) begin
    if (RST)           sig <= load_val;
    else if (load)     sig <= load_val;
    else if (shift_en) sig <= misr_next(sig, din);
  end

endmodule

// File: rtl/bist_resp_analyzer.sv
// BIST response analyzer: compacts CUT response beats into a MISR signature and
// checks it against GOLDEN at the end of the run.
// Optional macro BRA_COUNT_CHECK_EN also requires exactly N_PATTERNS beats.
module bist_resp_analyzer
  import bist_resp_analyzer_pkg::*;
#(
  parameter int               SIG_W      = DEF_SIG_W,
  parameter int               IN_W       = 2,
  parameter logic [SIG_W-1:0] POLY       = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED       = '0,
  parameter logic [SIG_W-1:0] GOLDEN     = '0,
  parameter int               N_PATTERNS = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_start,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [IN_W-1:0]  in_resp,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_pass_fail,
  output logic [SIG_W-1:0] out_signature
);

  bra_state_e state_q, state_d;
  logic       run_load;
  logic       beat_en;
  logic       count_ok;
  logic       pass_fail_q;

  assign run_load = ((state_q == IDLE) || (state_q == DONE)) && in_start;
  assign beat_en  = (state_q == COMPACT) && in_valid;

  misr_core #(
    .SIG_W (SIG_W),
    .IN_W  (IN_W),
    .POLY  (POLY)
  ) u_misr (
    .CLK      (CLK),
    .RST      (RST),
    .load     (run_load),
    .load_val (SEED),
    .shift_en (beat_en),
    .din      (in_resp),
    .sig      (out_signature)
  );

`ifdef BRA_COUNT_CHECK_EN
  localparam int CNT_W = $clog2(N_PATTERNS + 2);
  logic [CNT_W-1:0] count_q;

  // Saturates so an overlong run can never wrap back onto N_PATTERNS.
  always_ff @(posedge CLK) begin
    if (RST)                             count_q <= '0;
    else if (run_load)                   count_q <= '0;
    else if (beat_en && (count_q != '1)) count_q <= count_q + 1'b1;
  end

  assign count_ok = (count_q == CNT_W'(N_PATTERNS));
`else
  logic unused_cfg;
  assign unused_cfg = ^N_PATTERNS;
  assign count_ok   = 1'b1;
`endif

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_start) state_d = COMPACT;
      COMPACT: if (in_valid && in_last) state_d = COMPARE;
      COMPARE: state_d = DONE;
      DONE:    if (in_start) state_d = COMPACT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST)                     pass_fail_q <= 1'b0;
    else if (run_load)           pass_fail_q <= 1'b0;
    else if (state_q == COMPARE) pass_fail_q <= (out_signature == GOLDEN) && count_ok;
  end

  assign out_busy      = (state_q == COMPACT) || (state_q == COMPARE);
  assign out_done      = (state_q == DONE);
  assign out_pass_fail = pass_fail_q;

endmodule

// File: tb/tb_bist_resp_analyzer.sv
// Directed bench for bist_resp_analyzer: three instances (GOLDEN 4, GOLDEN 5,
// SEED 8) share one stimulus stream; a vector table plus hand-written sequences.
module tb_bist_resp_analyzer;

`ifdef BRA_COUNT_CHECK_EN
  localparam bit CNT_CHK = 1'b1;
`else
  localparam bit CNT_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start, valid, last;
  logic [1:0] resp;

  logic       busy_a, done_a, pf_a;
  logic       busy_b, done_b, pf_b;
  logic       busy_c, done_c, pf_c;
  logic [3:0] sig_a, sig_b, sig_c;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bist_resp_analyzer #(.SIG_W(4), .IN_W(2), .POLY(4'b0011), .SEED(4'h0),
                       .GOLDEN(4'h4), .N_PATTERNS(4)) dut_a (
    .CLK(clk), .RST(rst), .in_start(start), .in_valid(valid), .in_last(last),
    .in_resp(resp), .out_busy(busy_a), .out_done(done_a),
    .out_pass_fail(pf_a), .out_signature(sig_a));

  bist_resp_analyzer #(.SIG_W(4), .IN_W(2), .POLY(4'b0011), .SEED(4'h0),
                       .GOLDEN(4'h5), .N_PATTERNS(4)) dut_b (
    .CLK(clk), .RST(rst), .in_start(start), .in_valid(valid), .in_last(last),
    .in_resp(resp), .out_busy(busy_b), .out_done(done_b),
    .out_pass_fail(pf_b), .out_signature(sig_b));

  bist_resp_analyzer #(.SIG_W(4), .IN_W(2), .POLY(4'b0011), .SEED(4'h8),
                       .GOLDEN(4'h3), .N_PATTERNS(4)) dut_c (
    .CLK(clk), .RST(rst), .in_start(start), .in_valid(valid), .in_last(last),
    .in_resp(resp), .out_busy(busy_c), .out_done(done_c),
    .out_pass_fail(pf_c), .out_signature(sig_c));

  typedef struct {
    string      name;
    logic       s, v, l;
    logic [1:0] r;
    logic       busy, done, pfa, pfb, pfc;
    logic [3:0] siga, sigc;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic l, input logic [1:0] r);
    start = s; valid = v; last = l; resp = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; last = 1'b0; resp = 2'b00;

    // Expected values: MISR with POLY 0011; seed 0 -> 1,3,4; seed 8 -> 2,5,8
    tbl[0]  = '{"start_ignores_beat", 1,1,0,2'b11, 1,0,0,0,0, 4'h0,4'h8};
    tbl[1]  = '{"beat1",              0,1,0,2'b01, 1,0,0,0,0, 4'h1,4'h2};
    tbl[2]  = '{"beat2",              0,1,0,2'b01, 1,0,0,0,0, 4'h3,4'h5};
    tbl[3]  = '{"last_without_valid", 0,0,1,2'b10, 1,0,0,0,0, 4'h3,4'h5};
    tbl[4]  = '{"start_in_compact",   1,0,0,2'b00, 1,0,0,0,0, 4'h3,4'h5};
    tbl[5]  = '{"last_beat",          0,1,1,2'b10, 1,0,0,0,0, 4'h4,4'h8};
    tbl[6]  = '{"done_run1",          0,0,0,2'b00, 0,1,!CNT_CHK,0,0, 4'h4,4'h8};
    tbl[7]  = '{"beat_in_done",       0,1,0,2'b11, 0,1,!CNT_CHK,0,0, 4'h4,4'h8};
    tbl[8]  = '{"restart_from_done",  1,0,0,2'b00, 1,0,0,0,0, 4'h0,4'h8};
    tbl[9]  = '{"msb_feedback_beat",  0,1,1,2'b00, 1,0,0,0,0, 4'h0,4'h3};
    tbl[10] = '{"done_run2",          0,0,0,2'b00, 0,1,0,0,!CNT_CHK, 4'h0,4'h3};

    idle(2);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pf",   pf_a,   0);
    chk("rst_sig_a", sig_a, 4'h0);
    chk("rst_sig_c", sig_c, 4'h8);
    rst = 1'b0;
    idle(1);
    chk("idle_busy", busy_a, 0);
    chk("idle_done", done_a, 0);

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].s, tbl[i].v, tbl[i].l, tbl[i].r);
      chk({tbl[i].name, "_busy"},  busy_a, tbl[i].busy);
      chk({tbl[i].name, "_done"},  done_a, tbl[i].done);
      chk({tbl[i].name, "_pf_a"},  pf_a,   tbl[i].pfa);
      chk({tbl[i].name, "_pf_b"},  pf_b,   tbl[i].pfb);
      chk({tbl[i].name, "_pf_c"},  pf_c,   tbl[i].pfc);
      chk({tbl[i].name, "_sig_a"}, sig_a,  tbl[i].siga);
      chk({tbl[i].name, "_sig_c"}, sig_c,  tbl[i].sigc);
    end

    // Gapped beats give the same signature and timing as the back-to-back run
    step(1, 0, 0, 2'b00);
    step(0, 1, 0, 2'b01);
    idle(3);
    chk("gap_sig_hold", sig_a, 4'h1);
    step(0, 1, 0, 2'b01);
    idle(3);
    step(0, 1, 1, 2'b10);
    chk("gap_sig_last", sig_a, 4'h4);
    chk("gap_compare_done", done_a, 0);
    idle(1);
    chk("gap_done", done_a, 1);
    chk("gap_pf_a", pf_a, !CNT_CHK);
    chk("gap_pf_b", pf_b, 0);
    chk("gap_sig_b", sig_b, 4'h4);

    // Start pulse mid-run must not restart; then reset aborts a run
    step(1, 0, 0, 2'b00);
    step(0, 1, 0, 2'b01);
    step(0, 1, 0, 2'b01);
    step(1, 0, 0, 2'b00);
    chk("restart_ignored_sig", sig_a, 4'h3);
    chk("restart_ignored_busy", busy_a, 1);
    step(0, 1, 1, 2'b10);
    idle(1);
    chk("cont_done", done_a, 1);
    chk("cont_sig", sig_a, 4'h4);
    chk("cont_pf", pf_a, !CNT_CHK);

    step(1, 0, 0, 2'b00);
    step(0, 1, 0, 2'b01);
    rst = 1'b1;
    step(0, 1, 0, 2'b01);
    rst = 1'b0;
    chk("midrst_busy", busy_a, 0);
    chk("midrst_done", done_a, 0);
    chk("midrst_sig_a", sig_a, 4'h0);
    chk("midrst_sig_c", sig_c, 4'h8);
    step(0, 1, 1, 2'b01);
    chk("midrst_idle_sig", sig_a, 4'h0);
    chk("midrst_idle_busy", busy_a, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
